// File: rtl/usb_tx_pkg.sv
// Shared constants, state encoding and CRC helper for the USB TX packet scheduler.
package usb_tx_pkg;

  localparam logic [7:0]  SYNC_BYTE    = 8'h80;
  localparam logic [3:0]  PID_ACK      = 4'h2;
  localparam logic [3:0]  PID_NAK      = 4'hA;
  localparam logic [3:0]  PID_STALL    = 4'hE;
  localparam logic [3:0]  PID_DATA0    = 4'h3;
  localparam logic [3:0]  PID_DATA1    = 4'hB;
  localparam logic [15:0] CRC16_POLY   = 16'hA001;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  localparam int          MAX_PKT_BITS = 544;

  localparam logic [1:0]  HS_ACK   = 2'b00;
  localparam logic [1:0]  HS_NAK   = 2'b01;
  localparam logic [1:0]  HS_STALL = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CRC,
    S_APPEND,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } tx_state_t;

  // The reserved code 11 is sent as STALL.
  function automatic logic [3:0] hs_pid_nibble(input logic [1:0] code);
    case (code)
      HS_ACK:  return PID_ACK;
      HS_NAK:  return PID_NAK;
      default: return PID_STALL;
    endcase
  endfunction

  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

  // Reflected CRC16 update for one byte, LSB of the byte consumed first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_tx_bit_timer.sv
// Fractional accumulator producing the line bit-rate enable from the system clock.
module usb_tx_bit_timer #(
  parameter int CLK_MHZ = 100,
  parameter int BIT_MHZ = 12
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_bit_en
);

  localparam int ACC_W = $clog2(CLK_MHZ + BIT_MHZ + 1);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_sum;
  logic             r_bit_en;

  assign w_sum    = r_acc + ACC_W'(BIT_MHZ);
  assign o_bit_en = r_bit_en;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_acc    <= '0;
      r_bit_en <= 1'b0;
    end else if (i_clr) begin
      r_acc    <= '0;
      r_bit_en <= 1'b0;
    end else if (i_en) begin
      if (w_sum >= ACC_W'(CLK_MHZ)) begin
        r_acc    <= w_sum - ACC_W'(CLK_MHZ);
        r_bit_en <= 1'b1;
      end else begin
        r_acc    <= w_sum;
        r_bit_en <= 1'b0;
      end
    end else begin
      r_bit_en <= 1'b0;
    end
  end

endmodule

// File: rtl/usb_tx_scheduler.sv
// Arbitrates handshake/data requests, assembles the TX packet vector and supervises loader completion.
module usb_tx_scheduler
  import usb_tx_pkg::*;
#(
  parameter int CLK_MHZ      = 100,
  parameter int BIT_MHZ      = 12,
  parameter int MAX_BYTES    = 64,
  parameter int TIMEOUT_BITS = 600
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         hs_req,
  input  logic [1:0]   hs_pid,
  input  logic         data_req,
  input  logic         data_toggle,
  input  logic [6:0]   buf_count,
  output logic         buf_rd_en,
  input  logic [7:0]   buf_rd_data,
  output logic         bit_en_TX,
  output logic [543:0] packet_TX,
  output logic [9:0]   packet_counter,
  output logic         copy_signal,
  output logic         packet_load_complete_TX,
  input  logic         complete_TX,
  output logic         tx_busy,
  output logic         tx_done,
  output logic         tx_error
);

  tx_state_t r_state, w_next;

  logic         r_hs_pend, r_data_pend;
  logic [1:0]   r_hs_pid;
  logic [6:0]   r_len, r_rd_idx, r_wr_idx;
  logic         r_wr_vld;
  logic [15:0]  r_crc;
  logic [543:0] r_pkt;
  logic [9:0]   r_pkt_cnt;
  logic [9:0]   r_bit_cnt;
  logic         r_tx_error;

  logic         w_bit_en, w_busy, w_idle;
  logic         w_grant_hs, w_grant_data, w_timeout;
  logic [6:0]   w_len;
  logic [3:0]   w_pid;
  logic [9:0]   w_wr_base, w_app_base;

  assign w_len      = (buf_count > 7'(MAX_BYTES)) ? 7'(MAX_BYTES) : buf_count;
  assign w_pid      = w_grant_hs ? hs_pid_nibble(r_hs_pid) : (data_toggle ? PID_DATA1 : PID_DATA0);
  assign w_wr_base  = 10'd16 + {r_wr_idx, 3'b000};
  assign w_app_base = 10'd16 + {r_len, 3'b000};
  assign w_idle     = (r_state == S_IDLE);
  assign w_busy     = !w_idle;

  usb_tx_bit_timer #(
    .CLK_MHZ (CLK_MHZ),
    .BIT_MHZ (BIT_MHZ)
  ) u_bit_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .i_en     (w_busy),
    .i_clr    (w_idle),
    .o_bit_en (w_bit_en)
  );

  always_comb begin
    w_next                  = r_state;
    w_grant_hs              = 1'b0;
    w_grant_data            = 1'b0;
    w_timeout               = 1'b0;
    buf_rd_en               = 1'b0;
    copy_signal             = 1'b0;
    packet_load_complete_TX = 1'b0;
    tx_done                 = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_hs_pend) begin
          w_grant_hs = 1'b1;
          w_next     = S_ISSUE;
        end else if (r_data_pend) begin
          w_grant_data = 1'b1;
          w_next       = (w_len == 7'd0) ? S_APPEND : S_FETCH;
        end
      end
      S_FETCH: begin
        buf_rd_en = 1'b1;
        if (r_rd_idx == r_len - 7'd1) w_next = S_CRC;
      end
      S_CRC:    w_next = S_APPEND;
      S_APPEND: w_next = S_ISSUE;
      S_ISSUE: begin
        copy_signal             = 1'b1;
        packet_load_complete_TX = 1'b1;
        w_next                  = S_WAIT;
      end
      S_WAIT: begin
        packet_load_complete_TX = 1'b1;
        // A completion arriving with the final allowed bit still counts as success.
        if (complete_TX) begin
          w_next = S_DONE;
        end else if (w_bit_en && (r_bit_cnt == 10'(TIMEOUT_BITS - 1))) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_DONE: begin
        tx_done = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_hs_pend   <= 1'b0;
      r_data_pend <= 1'b0;
      r_hs_pid    <= 2'b00;
      r_len       <= '0;
      r_rd_idx    <= '0;
      r_wr_idx    <= '0;
      r_wr_vld    <= 1'b0;
      r_crc       <= CRC16_INIT;
      r_pkt       <= '0;
      r_pkt_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_tx_error  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_tx_error <= w_timeout;

      // A new request in the grant cycle keeps the flag set.
      if (hs_req) begin
        r_hs_pend <= 1'b1;
        r_hs_pid  <= hs_pid;
      end else if (w_grant_hs) begin
        r_hs_pend <= 1'b0;
      end
      if (data_req)          r_data_pend <= 1'b1;
      else if (w_grant_data) r_data_pend <= 1'b0;

      if (w_grant_hs || w_grant_data) begin
        r_pkt     <= MAX_PKT_BITS'({pid_byte(w_pid), SYNC_BYTE});
        r_crc     <= CRC16_INIT;
        r_rd_idx  <= '0;
        r_len     <= w_grant_hs ? 7'd0 : w_len;
        r_pkt_cnt <= w_grant_hs ? 10'd16 : (10'd32 + {w_len, 3'b000});
      end

      if (r_state == S_FETCH) r_rd_idx <= r_rd_idx + 7'd1;

      // Buffer data lags its read strobe by one cycle.
      r_wr_vld <= buf_rd_en;
      r_wr_idx <= r_rd_idx;
      if (r_wr_vld) begin
        r_pkt[w_wr_base +: 8] <= buf_rd_data;
        r_crc                 <= crc16_byte(r_crc, buf_rd_data);
      end

      if (r_state == S_APPEND) r_pkt[w_app_base +: 16] <= ~r_crc;

      if (r_state == S_ISSUE)                   r_bit_cnt <= '0;
      else if ((r_state == S_WAIT) && w_bit_en) r_bit_cnt <= r_bit_cnt + 10'd1;
    end
  end

  assign bit_en_TX      = w_bit_en;
  assign packet_TX      = r_pkt;
  assign packet_counter = r_pkt_cnt;
  assign tx_busy        = w_busy;
  assign tx_error       = r_tx_error;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Directed-plus-random bench for usb_tx_scheduler against a packet/CRC/timing reference model.
module tb_usb_tx_scheduler;

  logic         clk = 1'b0;
  logic         n_rst, hs_req, data_req, data_toggle, complete_TX;
  logic [1:0]   hs_pid;
  logic [6:0]   buf_count;
  logic [7:0]   buf_rd_data;
  logic         buf_rd_en, bit_en_TX, copy_signal, packet_load_complete_TX;
  logic         tx_busy, tx_done, tx_error;
  logic [543:0] packet_TX;
  logic [9:0]   packet_counter;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem [64];
  int  rd_ptr, rd_cnt, copy_cnt, done_cnt, err_cnt, cyc, first_rd, last_rd;
  bit  rd_pend;

  usb_tx_scheduler dut (
    .clk                     (clk),
    .n_rst                   (n_rst),
    .hs_req                  (hs_req),
    .hs_pid                  (hs_pid),
    .data_req                (data_req),
    .data_toggle             (data_toggle),
    .buf_count               (buf_count),
    .buf_rd_en               (buf_rd_en),
    .buf_rd_data             (buf_rd_data),
    .bit_en_TX               (bit_en_TX),
    .packet_TX               (packet_TX),
    .packet_counter          (packet_counter),
    .copy_signal             (copy_signal),
    .packet_load_complete_TX (packet_load_complete_TX),
    .complete_TX             (complete_TX),
    .tx_busy                 (tx_busy),
    .tx_done                 (tx_done),
    .tx_error                (tx_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [543:0] got, input logic [543:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Bit-serial CRC over the first n buffer bytes, LSB of each byte first.
  function automatic logic [15:0] ref_crc(input int n);
    logic [15:0] c;
    bit fb;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++)
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ mem[k][b];
        c  = {1'b0, c[15:1]};
        if (fb) c = c ^ 16'hA001;
      end
    return c;
  endfunction

  function automatic logic [543:0] ref_pkt(input logic [3:0] pid, input int n, input bit is_data);
    logic [543:0] p;
    p        = '0;
    p[7:0]   = 8'h80;
    p[15:8]  = {~pid, pid};
    if (is_data) begin
      for (int k = 0; k < n; k++) p[16 + 8*k +: 8] = mem[k];
      p[16 + 8*n +: 16] = ~ref_crc(n);
    end
    return p;
  endfunction

  function automatic logic [3:0] hs_ref_pid(input logic [1:0] code);
    if (code == 2'b00) return 4'h2;
    if (code == 2'b01) return 4'hA;
    return 4'hE;
  endfunction

  // Busy-relative cycle of the j-th bit enable: first cycle where j*CLK <= BIT*cycles.
  function automatic int bit_offset(input int j);
    return (j * 100 + 11) / 12;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rd_pend) begin
      buf_rd_data = mem[rd_ptr[5:0]];
      rd_ptr++;
    end
    rd_pend = buf_rd_en;
    if (buf_rd_en) begin
      if (rd_cnt == 0) first_rd = cyc;
      last_rd = cyc;
      rd_cnt++;
    end
    if (copy_signal) copy_cnt++;
    if (tx_done)     done_cnt++;
    if (tx_error)    err_cnt++;
  endtask

  task automatic request_hs(input logic [1:0] code);
    hs_pid = code;
    hs_req = 1'b1;
    step();
    hs_req = 1'b0;
  endtask

  task automatic request_data(input logic tog, input int n);
    data_toggle = tog;
    buf_count   = 7'(n);
    rd_ptr      = 0;
    rd_cnt      = 0;
    data_req    = 1'b1;
    step();
    data_req = 1'b0;
  endtask

  task automatic wait_copy(input string tag);
    int t = 0;
    while (!copy_signal && t < 400) begin
      step();
      t++;
    end
    check({tag, "_copy_seen"}, 544'(copy_signal), 544'(1));
  endtask

  // At the ISSUE cycle: check the packet, then answer complete_TX after k bit enables.
  task automatic finish_pkt(input string tag, input logic [543:0] exp_pkt, input int exp_len,
                            input int k, input bit cadence);
    int issue_cyc, pulses, t;
    check({tag, "_pkt"}, packet_TX, exp_pkt);
    check({tag, "_len"}, 544'(packet_counter), 544'(exp_len));
    check({tag, "_loadc_issue"}, 544'(packet_load_complete_TX), 544'(1));
    issue_cyc = cyc;
    pulses = 0;
    t = 0;
    while (pulses < k && t < 3000) begin
      step();
      t++;
      if (bit_en_TX) begin
        pulses++;
        if (cadence && pulses <= 6)
          check({tag, "_bit_cadence"}, 544'(cyc - issue_cyc), 544'(bit_offset(pulses)));
      end
    end
    check({tag, "_pulses"}, 544'(pulses), 544'(k));
    check({tag, "_loadc_wait"}, 544'(packet_load_complete_TX), 544'(1));
    complete_TX = 1'b1;
    step();
    complete_TX = 1'b0;
    check({tag, "_done"}, 544'(tx_done), 544'(1));
    check({tag, "_loadc_done"}, 544'(packet_load_complete_TX), 544'(0));
    step();
    check({tag, "_idle"}, 544'(tx_busy), 544'(0));
    check({tag, "_hold_pkt"}, packet_TX, exp_pkt);
  endtask

  initial begin
    int n, k, d0, t, pulses;
    logic tog;
    n_rst = 1'b0; hs_req = 1'b0; data_req = 1'b0; data_toggle = 1'b0;
    complete_TX = 1'b0; hs_pid = 2'b00; buf_count = '0; buf_rd_data = '0;
    rd_ptr = 0; rd_cnt = 0; copy_cnt = 0; done_cnt = 0; err_cnt = 0; cyc = 0;
    rd_pend = 1'b0; first_rd = 0; last_rd = 0;
    step(); step();
    check("rst_busy", 544'(tx_busy), 544'(0));
    check("rst_pkt", packet_TX, '0);
    check("rst_len", 544'(packet_counter), 544'(0));
    check("rst_ctrl", 544'({buf_rd_en, bit_en_TX, copy_signal, packet_load_complete_TX, tx_done, tx_error}), 544'(0));
    n_rst = 1'b1;
    step();

    // ACK handshake with bit cadence
    request_hs(2'b00);
    wait_copy("ack");
    finish_pkt("ack", ref_pkt(4'h2, 0, 1'b0), 16, 16, 1'b1);
    check("ack_d280", 544'(packet_TX[15:0]), 544'(16'hD280));

    // complete_TX while idle has no effect
    complete_TX = 1'b1;
    step();
    complete_TX = 1'b0;
    step();
    check("idle_cmpl_done", 544'(tx_done), 544'(0));
    check("idle_cmpl_busy", 544'(tx_busy), 544'(0));

    // zero-length DATA1
    request_data(1'b1, 0);
    wait_copy("zlp");
    check("zlp_rd", 544'(rd_cnt), 544'(0));
    check("zlp_word", 544'(packet_TX[31:0]), 544'(32'h0000_4B80));
    finish_pkt("zlp", ref_pkt(4'hB, 0, 1'b1), 32, 3, 1'b0);

    // full 64-byte DATA0, bytes 00..3F
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    request_data(1'b0, 64);
    wait_copy("d64");
    check("d64_rd", 544'(rd_cnt), 544'(64));
    check("d64_contig", 544'(last_rd - first_rd + 1), 544'(64));
    finish_pkt("d64", ref_pkt(4'h3, 64, 1'b1), 544, 5, 1'b0);

    // random data packets
    for (int r = 0; r < 4; r++) begin
      n   = $urandom_range(1, 63);
      tog = 1'($urandom_range(0, 1));
      k   = $urandom_range(1, 12);
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
      request_data(tog, n);
      wait_copy("rnd");
      check("rnd_rd", 544'(rd_cnt), 544'(n));
      finish_pkt("rnd", ref_pkt(tog ? 4'hB : 4'h3, n, 1'b1), 32 + 8*n, k, 1'b0);
    end

    // simultaneous NAK and data request: NAK first, data follows unprompted
    d0 = done_cnt;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    hs_pid = 2'b01; hs_req = 1'b1;
    data_toggle = 1'b1; buf_count = 7'd5; rd_ptr = 0; rd_cnt = 0; data_req = 1'b1;
    step();
    hs_req = 1'b0; data_req = 1'b0;
    wait_copy("nak");
    check("nak_5a", 544'(packet_TX[15:0]), 544'(16'h5A80));
    finish_pkt("nak", ref_pkt(hs_ref_pid(2'b01), 0, 1'b0), 16, 2, 1'b0);
    wait_copy("after_nak");
    finish_pkt("after_nak", ref_pkt(4'hB, 5, 1'b1), 72, 4, 1'b0);
    check("two_done", 544'(done_cnt - d0), 544'(2));

    // timeout with no completion (reserved hs code is sent as STALL)
    request_hs(2'b11);
    wait_copy("to");
    check("to_pkt", packet_TX, ref_pkt(4'hE, 0, 1'b0));
    pulses = 0;
    t = 0;
    while (!tx_error && t < 6000) begin
      step();
      t++;
      if (bit_en_TX) pulses++;
    end
    check("to_error_seen", 544'(tx_error), 544'(1));
    check("to_pulses", 544'(pulses), 544'(600));
    check("to_loadc", 544'(packet_load_complete_TX), 544'(0));
    check("to_idle", 544'(tx_busy), 544'(0));
    check("to_no_done", 544'(tx_done), 544'(0));
    step();
    check("to_err_pulse", 544'(tx_error), 544'(0));
    request_hs(2'b10);
    wait_copy("post_to");
    finish_pkt("post_to", ref_pkt(4'hE, 0, 1'b0), 16, 1, 1'b0);

    // asynchronous reset in the middle of FETCH
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    request_data(1'b0, 40);
    t = 0;
    while (!buf_rd_en && t < 20) begin
      step();
      t++;
    end
    check("rst_fetch_seen", 544'(buf_rd_en), 544'(1));
    step(); step();
    hs_req = 1'b1; hs_pid = 2'b00;
    step();
    hs_req = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    check("arst_busy", 544'(tx_busy), 544'(0));
    check("arst_rd", 544'(buf_rd_en), 544'(0));
    check("arst_pkt", packet_TX, '0);
    check("arst_len", 544'(packet_counter), 544'(0));
    check("arst_ctrl", 544'({bit_en_TX, copy_signal, packet_load_complete_TX, tx_done, tx_error}), 544'(0));
    rd_pend = 1'b0;
    step(); step();
    n_rst = 1'b1;
    k = copy_cnt;
    d0 = done_cnt + err_cnt;
    for (int i = 0; i < 30; i++) step();
    check("arst_pend_lost", 544'(copy_cnt - k), 544'(0));
    check("arst_no_status", 544'(done_cnt + err_cnt - d0), 544'(0));
    check("arst_idle", 544'(tx_busy), 544'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/usb_tx_scheduler.md
Name: usb_tx_scheduler

Overview:
- Sequences the USB TX packet loader: arbitrates handshake vs data transmit requests, assembles the 544-bit packet vector (SYNC, PID, payload, CRC16), hands it to the loader and waits for completion.
- Generates the full-speed bit-rate enable (bit_en_TX) and supervises a completion timeout.
- Sits between the protocol/endpoint logic plus TX data buffer and the packet loader/NRZI output stage.

Parameters:
CLK_MHZ, 100, system clock frequency, used by the bit-enable accumulator
BIT_MHZ, 12, line bit rate
MAX_BYTES, 64, maximum payload bytes
TIMEOUT_BITS, 600, bit_en_TX pulses allowed in WAIT before abort

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
hs_req  in  1  pulse: request handshake packet
hs_pid  in  2  00 ACK, 01 NAK, 10 STALL, 11 reserved (treated as STALL)
data_req  in  1  pulse: request data packet
data_toggle  in  1  0 DATA0, 1 DATA1; sampled at grant
buf_count  in  7  payload bytes available (0..64); sampled at grant
buf_rd_en  out  1  TX buffer read strobe
buf_rd_data  in  8  buffer byte, valid the cycle after buf_rd_en
bit_en_TX  out  1  one-cycle bit-rate enable
packet_TX  out  544  packet vector; bit 0 transmitted first
packet_counter  out  10  total bits valid in packet_TX
copy_signal  out  1  one-cycle load strobe to loader
packet_load_complete_TX  out  1  packet valid, held until completion
complete_TX  in  1  loader reports EOP sent
tx_busy  out  1  state != IDLE
tx_done  out  1  one-cycle pulse on successful completion
tx_error  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset: all outputs 0, packet_TX 0, pending flags cleared, state IDLE, accumulator 0.
- Pending flags: hs_pend/data_pend set by request pulses, cleared at grant; set and clear in the same cycle -> set wins. hs_pid latched when hs_req is seen.
- Arbitration in IDLE: hs_pend has priority over data_pend; a pending data request survives a handshake transmission.
- Packet assembly: [7:0]=8'h80 (SYNC); [15:8]={~pid,pid} (ACK D2, NAK 5A, STALL 1E, DATA0 C3, DATA1 4B).
- Handshake: packet_counter=16; state goes IDLE->ISSUE.
- Data: IDLE->FETCH. One buf_rd_en per cycle for n=min(buf_count,64) cycles. Byte k is written to [16+8k +: 8] one cycle after its read. CRC16 (poly 8005 reflected A001, init FFFF) is updated per byte.
- Data, after the last byte: CRC state->APPEND writes ~crc LSB-first at [16+8n +: 16]; packet_counter=32+8n, max 544. n=0 goes directly to APPEND with CRC 0000.
- Unused packet_TX bits are driven 0.
- ISSUE (1 cycle): copy_signal=1; packet_load_complete_TX rises and holds. ISSUE->WAIT.
- WAIT: count bit_en_TX pulses.
  - complete_TX -> DONE.
  - count reaches TIMEOUT_BITS -> tx_error pulse, IDLE.
  - complete_TX on the same cycle as timeout -> success wins.
- DONE (1 cycle): tx_done=1, packet_load_complete_TX=0, then IDLE. packet_TX holds its last value until the next grant.
- Bit enable: accumulator += BIT_MHZ each clock while tx_busy. When acc >= CLK_MHZ, subtract CLK_MHZ and pulse bit_en_TX (8/8/9 cycle cadence). Accumulator is cleared in IDLE, so the first pulse occurs 9 cycles after ISSUE.
- complete_TX outside WAIT is ignored.
- Reset mid-operation aborts immediately: no tx_done/tx_error, pending requests lost.

Decomposition:
- Package usb_tx_pkg: PID constants, SYNC_BYTE, CRC16 poly/init, state enum, hs_pid encoding, MAX_PKT_BITS=544.
- Sub-module usb_tx_bit_timer: accumulator bit-enable generator with enable/clear.
- CRC byte update is a package function.

Test Plan:
- ACK: hs_req, hs_pid=00 -> one copy_signal, packet_counter=16, packet_TX[15:0]=16'hD280, load_complete held; complete_TX after 16 bit_en pulses -> tx_done next cycle, tx_busy drops.
- Zero-length DATA1: data_req, toggle=1, buf_count=0 -> no buf_rd_en, packet_counter=32, packet_TX[31:0]=32'h0000_4B80.
- 64-byte DATA0, buffer bytes 00..3F: 64 consecutive buf_rd_en, packet_counter=544, payload placed in order, CRC matches bench model.
- Simultaneous hs_req (NAK) and data_req: NAK (5A) sent first, then the data packet with no further request; two tx_done pulses.
- No complete_TX: tx_error after exactly 600 bit_en pulses in WAIT, load_complete drops, next request is served normally.
- Bit cadence and reset: bit_en spacing 9/8/8 repeating while busy; n_rst low during FETCH clears all outputs asynchronously, IDLE on release.
